// File: rtl/weight_rom_streamer.sv
// rtl/weight_rom_streamer.sv - weight ROM read sequencer presenting words as a valid/ready stream
module weight_rom_streamer #(
   parameter int ADDR_WIDTH = 3,
   parameter int WORD_SIZE  = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [WORD_SIZE-1:0]  rom_data_i,
   output logic [WORD_SIZE-1:0]  data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   remaining_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic [WORD_SIZE-1:0]  fifo_data_q [2];
   logic [1:0]            fifo_last_q;
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            fifo_count_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  accept;
   logic                  issue;
   logic                  last_issue;
   logic                  push;
   logic                  pop;
   logic                  head_last;
   logic [2:0]            credit;

   assign valid_o   = (fifo_count_q != 2'd0);
   assign head_last = fifo_last_q[rd_ptr_q];
   assign data_o    = fifo_data_q[rd_ptr_q];
   assign last_o    = valid_o & head_last;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

   assign pop    = valid_o & ready_i;
   assign push   = inflight_q;
   // done_q blocks a new start during the done pulse cycle
   assign accept = (state_q == IDLE) && start_i && !done_q;

   // Words held or on their way into the FIFO, net of the word leaving this cycle
   assign credit     = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue      = (state_q == FETCH) && (credit < 3'd2);
   assign last_issue = issue && (remaining_q == (ADDR_WIDTH+1)'(1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (len_i == '0) ? DONE : FETCH;
         FETCH:   if (last_issue) state_d = DRAIN;
         DRAIN:   if (pop && head_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q         <= IDLE;
         rom_addr_o      <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= '0;
         fifo_data_q[1]  <= '0;
         fifo_last_q     <= '0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         fifo_count_q    <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == DONE);

         if (accept) begin
            rom_addr_o  <= base_addr_i;
            remaining_q <= len_i;
            busy_q      <= 1'b1;
         end else if (state_q == DONE) begin
            busy_q <= 1'b0;
         end

         inflight_q      <= issue;
         inflight_last_q <= last_issue;
         if (issue) begin
            rom_addr_o  <= rom_addr_o + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
         end

         // ROM output corresponds to the address issued on the previous edge
         if (push) begin
            fifo_data_q[wr_ptr_q] <= rom_data_i;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;

         case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
            2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(push && !pop && fifo_count_q == 2'd2));

endmodule

// File: tb/tb_weight_rom_streamer.sv
// tb/tb_weight_rom_streamer.sv - scoreboard bench for weight_rom_streamer
module tb_weight_rom_streamer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] base_addr = '0;
   logic [3:0] len = '0;
   logic [2:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       last;
   logic       busy;
   logic       done;

   weight_rom_streamer #(.ADDR_WIDTH(3), .WORD_SIZE(8)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .base_addr_i(base_addr),
      .len_i(len), .rom_addr_o(rom_addr), .rom_data_i(rom_data), .data_o(data),
      .valid_o(valid), .ready_i(ready), .last_o(last), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [8];
   initial for (int i = 0; i < 8; i++) rom[i] = 8'(i) + 8'h10;
   always @(posedge clk) rom_data <= rom[rom_addr];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;
   bit rand_mode = 1'b0;
   bit ready_fixed = 1'b1;
   bit track = 1'b0;
   logic [2:0] trk_base = '0;
   int max_lead = 0;
   logic [9:0] sb_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      ready = rand_mode ? ($urandom_range(0, 9) >= 3) : ready_fixed;
   end

   bit         prev_valid = 1'b0;
   bit         prev_ready = 1'b0;
   logic [8:0] prev_word = '0;
   bit         track_prev = 1'b0;
   logic [2:0] prev_addr = '0;
   int         issued = 0;
   int         xfers = 0;

   always @(negedge clk) begin
      logic [9:0] exp_word;
      if (!reset_n) begin
         prev_valid = 1'b0;
      end else begin
         if (track && !track_prev) begin
            prev_addr = trk_base; issued = 0; xfers = 0; max_lead = 0;
         end
         track_prev = track;
         if (track) begin
            if (rom_addr != prev_addr) begin issued++; prev_addr = rom_addr; end
            if (issued - xfers > max_lead) max_lead = issued - xfers;
         end
         if (prev_valid && !prev_ready)
            check("stall_stable", {valid, last, data}, {1'b1, prev_word});
         if (valid && ready) begin
            exp_word = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
            check("stream_word", {1'b0, last, data}, exp_word);
            if (last) last_cyc = cyc;
            xfers++;
         end
         prev_valid = valid;
         prev_ready = ready;
         prev_word  = {last, data};
      end
   end

   task automatic do_start(input logic [2:0] b, input logic [3:0] l);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = l;
      for (int i = 0; i < int'(l); i++) begin
         logic [2:0] a;
         a = b + 3'(i);
         sb_q.push_back({1'b0, (i == int'(l) - 1), 8'(a) + 8'h10});
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input bit lat);
      int n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 200);
      check("done_seen", done, 1);
      if (lat) check("done_latency", cyc - last_cyc, 2);
      check("busy_at_done", busy, 0);
      check("sb_drained", sb_q.size(), 0);
      @(negedge clk);
      check("done_pulse", done, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {valid, last, busy, done, data, rom_addr}, 0);
      reset_n = 1'b1;

      // full pass, latency and throughput
      do_start(3'd0, 4'd8);
      check("busy_start", busy, 1);
      check("valid_n0", valid, 0);
      @(posedge clk); #1;
      check("valid_n1", valid, 0);
      @(posedge clk); #1;
      check("valid_n2", valid, 1);
      check("first_word", data, 8'h10);
      wait_done(1'b1);

      // address wrap
      do_start(3'd6, 4'd4);
      wait_done(1'b1);

      // random backpressure with lead tracking
      rand_mode = 1'b1;
      trk_base  = 3'd1;
      do_start(3'd1, 4'd8);
      track = 1'b1;
      wait_done(1'b1);
      track = 1'b0;
      rand_mode = 1'b0;
      check("max_lead", (max_lead <= 2), 1);

      // zero length
      do_start(3'd4, 4'd0);
      check("len0_busy", busy, 1);
      check("len0_done_early", done, 0);
      @(negedge clk);
      check("len0_valid", valid, 0);
      @(posedge clk); #1;
      check("len0_busy_fall", busy, 0);
      check("len0_done", done, 1);
      @(posedge clk); #1;
      check("len0_done_pulse", done, 0);
      check("len0_valid2", valid, 0);

      // start while busy is ignored
      do_start(3'd0, 4'd8);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 3'd3; len = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_mid", busy, 1);
      wait_done(1'b1);

      // asynchronous reset mid-pass
      ready_fixed = 1'b0;
      repeat (2) @(posedge clk);
      do_start(3'd2, 4'd8);
      repeat (3) @(posedge clk);
      #1;
      check("valid_before_rst", valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_outputs", {valid, last, busy, done, data, rom_addr}, 0);
      sb_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      ready_fixed = 1'b1;
      repeat (2) @(posedge clk);
      do_start(3'd5, 4'd3);
      wait_done(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
